// File: rtl/mac_acc_drain.sv
// Accumulator read-out: snapshots four lanes on start and streams them as OUT_WIDTH-bit beats, LSB first.
// Optional feature macro: MAC_DRAIN_CKSUM_EN appends one XOR checksum beat after the data beats.
module mac_acc_drain #(
  parameter int MAC_MIN_WIDTH = 8,
  parameter int MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH,
  parameter int OUT_WIDTH     = MAC_MIN_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [MAC_ACC_WIDTH-1:0] acc0,
  input  logic [MAC_ACC_WIDTH-1:0] acc1,
  input  logic [MAC_ACC_WIDTH-1:0] acc2,
  input  logic [MAC_ACC_WIDTH-1:0] acc3,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     out_eop,
  output logic                     busy,
  output logic                     done
);

  localparam int BEATS  = 4 * MAC_ACC_WIDTH / OUT_WIDTH;
  localparam int LBEATS = MAC_ACC_WIDTH / OUT_WIDTH;
  localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  // Mode encodings shared with the MAC array.
  localparam logic [1:0] MAC_SINGLE = 2'd0;
  localparam logic [1:0] MAC_DUAL   = 2'd1;
  localparam logic [1:0] MAC_QUAD   = 2'd2;

`ifdef MAC_DRAIN_CKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CKSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t                     state, state_next;
  logic [4*MAC_ACC_WIDTH-1:0] snap;
  logic [1:0]                 mode_q;
  logic [CW-1:0]              beat;
  logic                       done_q;
  logic                       beat_last;
  logic [31:0]                k;
`ifdef MAC_DRAIN_CKSUM_EN
  logic [OUT_WIDTH-1:0]       cksum;
`endif

  // Valid/ready: a beat transfers on a cycle where out_valid && out_ready; while
  // out_valid is high and out_ready is low, data/last/eop are held unchanged.
  always_comb begin
    k = 32'(beat);
    case (mode_q)
      MAC_DUAL: beat_last = ((k % 32'(2 * LBEATS)) == 32'(2 * LBEATS - 1));
      MAC_QUAD: beat_last = (beat == LAST_BEAT);
      default:  beat_last = ((k % 32'(LBEATS)) == 32'(LBEATS - 1));
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    out_eop    = 1'b0;
    case (state)
      IDLE: if (start) state_next = SEND;
      SEND: begin
        out_valid = 1'b1;
        out_data  = snap[beat*OUT_WIDTH +: OUT_WIDTH];
        out_last  = beat_last;
`ifdef MAC_DRAIN_CKSUM_EN
        if (out_ready && beat == LAST_BEAT) state_next = CKSUM;
`else
        out_eop   = (beat == LAST_BEAT);
        if (out_ready && beat == LAST_BEAT) state_next = IDLE;
`endif
      end
`ifdef MAC_DRAIN_CKSUM_EN
      CKSUM: begin
        out_valid = 1'b1;
        out_data  = cksum;
        out_last  = 1'b1;
        out_eop   = 1'b1;
        if (out_ready) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Snapshot is only loaded from IDLE, so start while draining cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap   <= '0;
      mode_q <= '0;
      beat   <= '0;
      done_q <= 1'b0;
`ifdef MAC_DRAIN_CKSUM_EN
      cksum  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          snap   <= {acc3, acc2, acc1, acc0};
          mode_q <= mode;
          beat   <= '0;
`ifdef MAC_DRAIN_CKSUM_EN
          cksum  <= '0;
`endif
        end
        SEND: if (out_ready) begin
`ifdef MAC_DRAIN_CKSUM_EN
          cksum <= cksum ^ out_data;
`endif
          if (beat == LAST_BEAT) begin
            beat <= '0;
`ifndef MAC_DRAIN_CKSUM_EN
            done_q <= 1'b1;
`endif
          end else begin
            beat <= beat + 1'b1;
          end
        end
`ifdef MAC_DRAIN_CKSUM_EN
        CKSUM: if (out_ready) done_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;

endmodule
